// File: rtl/ftdi_fifo_bridge_if.sv
// FTDI 245-FIFO pin group plus the core-side RX/TX stream ports of the bridge.
interface ftdi_fifo_bridge_if #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   // FTDI chip pins
   logic          rxf_n;
   logic          txe_n;
   logic [DW-1:0] adbus_in;
   logic [DW-1:0] adbus_out;
   logic          adbus_oe;
   logic          ftdi_rd_n;
   logic          ftdi_wr_n;

   // Core-side streams
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [CW-1:0] rx_count;
   logic [CW-1:0] tx_count;

   modport master (
      input  rxf_n, txe_n, adbus_in, rx_ready, tx_data, tx_valid,
      output adbus_out, adbus_oe, ftdi_rd_n, ftdi_wr_n,
             rx_data, rx_valid, tx_ready, rx_count, tx_count
   );

   modport slave (
      output rxf_n, txe_n, adbus_in, rx_ready, tx_data, tx_valid,
      input  adbus_out, adbus_oe, ftdi_rd_n, ftdi_wr_n,
             rx_data, rx_valid, tx_ready, rx_count, tx_count
   );
endinterface

// File: rtl/ftdi_fifo_bridge.sv
// Async FTDI 245-FIFO bus master with timed RD#/WR# strobes, ADBUS direction
// control, and RX/TX FIFOs towards the core.
module ftdi_fifo_bridge #(
   parameter int unsigned DW         = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned RD_CYCLES  = 4,
   parameter int unsigned WR_CYCLES  = 4,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned PRIORITY   = 0
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               en,
   ftdi_fifo_bridge_if.master bus
);
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned TM1  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int unsigned TMAX = (TM1 > GAP_CYCLES) ? TM1 : GAP_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_STROBE, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD, S_GAP
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            next_wr_q, next_wr_d;
   logic            rxf_meta_q, rxf_s_q, txe_meta_q, txe_s_q;
   logic            rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
   logic [DW-1:0]   dout_q, dout_d;

   logic [DW-1:0]   rx_mem [DEPTH];
   logic [AW-1:0]   rx_wp_q, rx_rp_q;
   logic [CW-1:0]   rx_cnt_q;
   logic [DW-1:0]   tx_mem [DEPTH];
   logic [AW-1:0]   tx_wp_q, tx_rp_q;
   logic [CW-1:0]   tx_cnt_q;

   logic            rx_push_c, rx_pop_c, tx_push_c, tx_pop_c;
   logic            rd_ok_c, wr_ok_c, pick_wr_c, tx_ready_c;

   assign tx_ready_c = (tx_cnt_q != CW'(DEPTH));
   assign rx_pop_c   = bus.rx_ready & (rx_cnt_q != '0);
   assign tx_push_c  = bus.tx_valid & tx_ready_c;

   // Two-flop synchronisers for the asynchronous FTDI status lines
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rxf_meta_q <= 1'b1;
         rxf_s_q    <= 1'b1;
         txe_meta_q <= 1'b1;
         txe_s_q    <= 1'b1;
      end else begin
         rxf_meta_q <= bus.rxf_n;
         rxf_s_q    <= rxf_meta_q;
         txe_meta_q <= bus.txe_n;
         txe_s_q    <= txe_meta_q;
      end
   end

   // Arbitration between a pending read and a pending write
   always_comb begin
      rd_ok_c   = en & ~rxf_s_q & (rx_cnt_q < CW'(DEPTH));
      wr_ok_c   = en & ~txe_s_q & (tx_cnt_q != '0);
      pick_wr_c = wr_ok_c;
      if (rd_ok_c && wr_ok_c) begin
         if (PRIORITY == 1)      pick_wr_c = 1'b0;
         else if (PRIORITY == 2) pick_wr_c = 1'b1;
         else                    pick_wr_c = next_wr_q;
      end
   end

   // FSM state register, strobe timer and registered pin outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         next_wr_q <= 1'b0;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         oe_q      <= 1'b0;
         dout_q    <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         next_wr_q <= next_wr_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         oe_q      <= oe_d;
         dout_q    <= dout_d;
      end
   end

   // Next-state logic; GAP lasts GAP_CYCLES-1 clocks, IDLE supplies the last idle clock
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      next_wr_d = next_wr_q;
      rx_push_c = 1'b0;
      tx_pop_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rd_ok_c || wr_ok_c) begin
               tmr_d     = '0;
               next_wr_d = ~pick_wr_c;
               if (pick_wr_c) begin
                  state_d  = S_WR_SETUP;
                  tx_pop_c = 1'b1;
               end else begin
                  state_d  = S_RD_STROBE;
               end
            end
         end
         S_RD_STROBE: begin
            if (tmr_q == TW'(RD_CYCLES - 1)) begin
               state_d   = S_GAP;
               tmr_d     = '0;
               rx_push_c = 1'b1;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_WR_SETUP: begin
            state_d = S_WR_STROBE;
            tmr_d   = '0;
         end
         S_WR_STROBE: begin
            if (tmr_q == TW'(WR_CYCLES - 1)) begin
               state_d = S_WR_HOLD;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_WR_HOLD: begin
            state_d = S_GAP;
            tmr_d   = '0;
         end
         S_GAP: begin
            if (tmr_q == TW'(GAP_CYCLES - 2)) begin
               state_d = S_IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pin outputs decoded from the next state so they register in step with the FSM
   always_comb begin
      rd_n_d = (state_d != S_RD_STROBE);
      wr_n_d = (state_d != S_WR_STROBE);
      oe_d   = (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) ||
               (state_d == S_WR_HOLD);
      dout_d = tx_pop_c ? tx_mem[tx_rp_q] : dout_q;
   end

   // RX FIFO storage (host -> core)
   always_ff @(posedge clock) begin
      if (rx_push_c) rx_mem[rx_wp_q] <= bus.adbus_in;
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (rx_push_c) rx_wp_q <= rx_wp_q + AW'(1);
         if (rx_pop_c)  rx_rp_q <= rx_rp_q + AW'(1);
         if (rx_push_c && !rx_pop_c)      rx_cnt_q <= rx_cnt_q + CW'(1);
         else if (!rx_push_c && rx_pop_c) rx_cnt_q <= rx_cnt_q - CW'(1);
      end
   end

   // TX FIFO storage (core -> host)
   always_ff @(posedge clock) begin
      if (tx_push_c) tx_mem[tx_wp_q] <= bus.tx_data;
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_push_c) tx_wp_q <= tx_wp_q + AW'(1);
         if (tx_pop_c)  tx_rp_q <= tx_rp_q + AW'(1);
         if (tx_push_c && !tx_pop_c)      tx_cnt_q <= tx_cnt_q + CW'(1);
         else if (!tx_push_c && tx_pop_c) tx_cnt_q <= tx_cnt_q - CW'(1);
      end
   end

   assign bus.adbus_out = dout_q;
   assign bus.adbus_oe  = oe_q;
   assign bus.ftdi_rd_n = rd_n_q;
   assign bus.ftdi_wr_n = wr_n_q;
   assign bus.rx_data   = rx_mem[rx_rp_q];
   assign bus.rx_valid  = (rx_cnt_q != '0);
   assign bus.tx_ready  = tx_ready_c;
   assign bus.rx_count  = rx_cnt_q;
   assign bus.tx_count  = tx_cnt_q;
endmodule
